m_axi_lite: RTL and testbench
=============================

M_AXI_LITE -- requirements
Module: m_axi_lite

Interface
REQ-001 SHALL have parameter M_AXI_DATA_WIDTH, default 32, data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter M_AXI_ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have one clock and a synchronous, active-high reset: m_axi_clk input 1 (all logic on rising edge); m_axi_reset input 1 (synchronous, active-high).
REQ-004 SHALL have cmd_valid input 1 (user command request); cmd_ready output 1 (command accepted when cmd_valid & cmd_ready).
REQ-005 SHALL have cmd_rnw input 1 (1 = read, 0 = write) and cmd_addr input M_AXI_ADDR_WIDTH (byte address).
REQ-006 SHALL have cmd_wdata input M_AXI_DATA_WIDTH and cmd_wstrb input M_AXI_DATA_WIDTH/8 (write data and byte strobes).
REQ-007 SHALL have rsp_valid output 1, rsp_ready input 1, rsp_rnw output 1, rsp_rdata output M_AXI_DATA_WIDTH and rsp_resp output 2 (completion to user).
REQ-008 SHALL have err_count output 8 (saturating count of non-OKAY responses).
REQ-009 SHALL have AXI4-Lite initiator ports: m_axi_awvalid out 1, m_axi_awaddr out ADDR, m_axi_awready in 1; m_axi_wvalid out 1, m_axi_wdata out DATA, m_axi_wstrb out DATA/8, m_axi_wready in 1; m_axi_bvalid in 1, m_axi_bresp in 2, m_axi_bready out 1; m_axi_arvalid out 1, m_axi_araddr out ADDR, m_axi_arready in 1; m_axi_rvalid in 1, m_axi_rdata in DATA, m_axi_rresp in 2, m_axi_rready out 1.

Function
REQ-010 SHALL run one FSM with states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE; exactly one transaction in flight.
REQ-011 SHALL assert cmd_ready combinationally only in IDLE; on cmd handshake it SHALL register addr/wdata/wstrb/rnw and move to WR_REQ (rnw=0) or RD_REQ (rnw=1) next cycle.
REQ-012 SHALL, on entering WR_REQ, assert m_axi_awvalid and m_axi_wvalid together in the same cycle, driving the registered address unmodified (byte address, no shifting).
REQ-013 SHALL hold awvalid until the AW handshake and wvalid until the W handshake, independently; neither SHALL drop before its handshake, and address/data/strobe SHALL stay stable while valid.
REQ-014 SHALL leave WR_REQ for WR_RESP in the cycle after both handshakes are done, including both in the same cycle or in either order.
REQ-015 SHALL assert m_axi_bready only in WR_RESP; on B handshake it SHALL capture bresp into rsp_resp, set rsp_rdata to 0, and move to DONE.
REQ-016 SHALL assert m_axi_arvalid in RD_REQ until the AR handshake, then move to RD_RESP.
REQ-017 SHALL assert m_axi_rready only in RD_RESP; on R handshake it SHALL capture rdata into rsp_rdata and rresp into rsp_resp, then move to DONE.
REQ-018 SHALL assert rsp_valid only in DONE, holding rsp_rdata/rsp_resp/rsp_rnw stable until rsp_ready; on rsp handshake it SHALL return to IDLE.
REQ-019 SHALL increment err_count by 1 when a B or R handshake carries resp != 2'b00; at 8'hFF it SHALL saturate.
REQ-020 SHALL ignore bvalid/rvalid outside WR_RESP/RD_RESP (no capture, no count).
REQ-021 SHALL give minimum latency with a zero-wait responder: cmd accept (cycle 0) -> AW/W valid (cycle 1) -> B ready (cycle 2) -> rsp_valid (cycle 3 if bvalid present in cycle 2).

Reset
REQ-022 SHALL, while m_axi_reset is high at a clock edge, go to IDLE and drive awvalid, wvalid, bready, arvalid, rready, rsp_valid = 0, with rsp_resp = 0, rsp_rdata = 0 and err_count = 0.
REQ-023 SHALL, on reset mid-transaction, abandon the transaction without completion; cmd_ready SHALL be 1 the first cycle after reset deasserts.

Verification
REQ-024 Write 0x0000_0008, data 0xDEADBEEF, strb 4'hF, responder ready at once, bresp OKAY -> awaddr=0x8, wdata=0xDEADBEEF on cycle 1; rsp_valid with rsp_resp=0, rsp_rnw=0; err_count=0.
REQ-025 Write with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles with stable awaddr, single B accepted, single rsp.
REQ-026 Read 0x0000_0004, responder returns rdata 0x12345678, rresp OKAY after 2-cycle rvalid delay -> rsp_rdata=0x12345678, rsp_resp=0, rsp_rnw=1.
REQ-027 Read 0x0000_0040 with responder rresp SLVERR 2'b10 -> rsp_resp=2'b10, err_count=1; 256 more errors -> err_count=0xFF.
REQ-028 rsp_ready held low 5 cycles -> rsp_valid and data stable for 5 cycles, cmd_ready=0 throughout; new command accepted only after rsp handshake.
REQ-029 Reset asserted in WR_RESP with bready high -> next cycle all valid/ready outputs 0 and err_count=0; after release, a fresh read completes normally.

Source files
------------

// File: rtl/m_axi_lite.sv
// Single-outstanding AXI4-Lite initiator: accepts one user command, runs the
// matching AXI write or read, and hands the completion back to the user.
module m_axi_lite #(
    parameter int unsigned M_AXI_DATA_WIDTH = 32,
    parameter int unsigned M_AXI_ADDR_WIDTH = 32
) (
    input  logic                          m_axi_clk,
    input  logic                          m_axi_reset,
    // User command
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_rnw,
    input  logic [M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    // User completion
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_rnw,
    output logic [M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic [7:0]                    err_count,
    // AXI4-Lite write address
    output logic                          m_axi_awvalid,
    output logic [M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    input  logic                          m_axi_awready,
    // AXI4-Lite write data
    output logic                          m_axi_wvalid,
    output logic [M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    input  logic                          m_axi_wready,
    // AXI4-Lite write response
    input  logic                          m_axi_bvalid,
    input  logic [1:0]                    m_axi_bresp,
    output logic                          m_axi_bready,
    // AXI4-Lite read address
    output logic                          m_axi_arvalid,
    output logic [M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    input  logic                          m_axi_arready,
    // AXI4-Lite read data
    input  logic                          m_axi_rvalid,
    input  logic [M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    output logic                          m_axi_rready
);

    localparam int unsigned StrbWidth = M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        StIdle, StWrReq, StWrResp, StRdReq, StRdResp, StDone
    } state_e;

    state_e                        state_q, state_d;
    logic [M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [StrbWidth-1:0]          wstrb_q, wstrb_d;
    logic                          rnw_q, rnw_d;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q, wvalid_d;
    logic                          bready_q, bready_d;
    logic                          arvalid_q, arvalid_d;
    logic                          rready_q, rready_d;
    logic                          rsp_valid_q, rsp_valid_d;
    logic [M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                    rsp_resp_q, rsp_resp_d;
    logic [7:0]                    err_count_q, err_count_d;
    logic                          err_inc;

    // Next-state logic: FSM transitions, registered AXI handshake signals and capture
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rnw_d       = rnw_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        err_count_d = err_count_q;
        err_inc     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    rnw_d   = cmd_rnw;
                    if (cmd_rnw) begin
                        state_d   = StRdReq;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = StWrReq;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end
            StWrReq: begin
                // AW and W complete independently; a channel stays valid only until it handshakes
                awvalid_d = awvalid_q & ~m_axi_awready;
                wvalid_d  = wvalid_q & ~m_axi_wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = StWrResp;
                    bready_d = 1'b1;
                end
            end
            StWrResp: begin
                if (m_axi_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axi_bresp;
                    err_inc     = (m_axi_bresp != 2'b00);
                    state_d     = StDone;
                end
            end
            StRdReq: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdResp;
                end
            end
            StRdResp: begin
                if (m_axi_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    err_inc     = (m_axi_rresp != 2'b00);
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (err_inc && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // State and registered outputs, synchronous reset abandons any transaction
    always_ff @(posedge m_axi_clk) begin
        if (m_axi_reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rnw_q       <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rnw_q       <= rnw_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            err_count_q <= err_count_d;
        end
    end

    assign cmd_ready     = (state_q == StIdle);
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_rready  = rready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rnw       = rnw_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_m_axi_lite.sv
// Directed bench for m_axi_lite with a configurable-delay AXI4-Lite responder
// and a queue of expected completions.
module tb_m_axi_lite;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_rnw;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  err_count;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_wvalid, m_axi_wready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_bvalid, m_axi_bready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;

    always #5 clk = ~clk;

    m_axi_lite #(
        .M_AXI_DATA_WIDTH(32),
        .M_AXI_ADDR_WIDTH(32)
    ) dut (
        .m_axi_clk    (clk),
        .m_axi_reset  (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rnw      (cmd_rnw),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rnw      (rsp_rnw),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .err_count    (err_count),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awready(m_axi_awready),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wstrb  (m_axi_wstrb),
        .m_axi_wready (m_axi_wready),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bresp  (m_axi_bresp),
        .m_axi_bready (m_axi_bready),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arready(m_axi_arready),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rready (m_axi_rready)
    );

    typedef struct packed {
        logic        rnw;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   err_exp  = 0;

    // Responder configuration
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [31:0] r_data_cfg = 32'h0;
    bit          spur = 1'b0;

    // Responder observations
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int          aw_high = 0, w_high = 0, aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    bit          aw_unstable = 1'b0, w_unstable = 1'b0;
    bit          aw_prev = 1'b0, w_prev = 1'b0;
    logic [31:0] last_awaddr = 32'h0, last_wdata = 32'h0;
    logic [3:0]  last_wstrb = 4'h0;
    logic [31:0] cap_awaddr = 32'h0, cap_wdata = 32'h0, cap_araddr = 32'h0;
    logic [3:0]  cap_wstrb = 4'h0;

    // Responder: drives ready/valid on the falling edge for the next rising edge
    initial begin
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = 32'h0;
        m_axi_rresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (m_axi_awvalid) begin
                if (aw_prev && (m_axi_awaddr !== last_awaddr)) aw_unstable = 1'b1;
                aw_high++;
                m_axi_awready = (aw_cnt >= aw_delay);
                aw_cnt++;
                if (m_axi_awready) begin
                    aw_hs++;
                    cap_awaddr = m_axi_awaddr;
                end
            end else begin
                m_axi_awready = 1'b0;
                aw_cnt = 0;
            end
            aw_prev     = m_axi_awvalid && !m_axi_awready;
            last_awaddr = m_axi_awaddr;

            if (m_axi_wvalid) begin
                if (w_prev && ((m_axi_wdata !== last_wdata) || (m_axi_wstrb !== last_wstrb)))
                    w_unstable = 1'b1;
                w_high++;
                m_axi_wready = (w_cnt >= w_delay);
                w_cnt++;
                if (m_axi_wready) begin
                    w_hs++;
                    cap_wdata = m_axi_wdata;
                    cap_wstrb = m_axi_wstrb;
                end
            end else begin
                m_axi_wready = 1'b0;
                w_cnt = 0;
            end
            w_prev     = m_axi_wvalid && !m_axi_wready;
            last_wdata = m_axi_wdata;
            last_wstrb = m_axi_wstrb;

            if (m_axi_bready) begin
                m_axi_bvalid = (b_cnt >= b_delay);
                m_axi_bresp  = b_resp_cfg;
                if (m_axi_bvalid) b_hs++;
                b_cnt++;
            end else begin
                b_cnt = 0;
                m_axi_bvalid = spur;
                m_axi_bresp  = spur ? 2'b10 : 2'b00;
            end

            if (m_axi_arvalid) begin
                m_axi_arready = (ar_cnt >= ar_delay);
                ar_cnt++;
                if (m_axi_arready) begin
                    ar_hs++;
                    cap_araddr = m_axi_araddr;
                end
            end else begin
                m_axi_arready = 1'b0;
                ar_cnt = 0;
            end

            if (m_axi_rready) begin
                m_axi_rvalid = (r_cnt >= r_delay);
                m_axi_rdata  = r_data_cfg;
                m_axi_rresp  = r_resp_cfg;
                if (m_axi_rvalid) r_hs++;
                r_cnt++;
            end else begin
                r_cnt = 0;
                m_axi_rvalid = spur;
                m_axi_rdata  = spur ? 32'hFFFF_FFFF : 32'h0;
                m_axi_rresp  = spur ? 2'b10 : 2'b00;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        aw_high = 0; w_high = 0; aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        aw_unstable = 1'b0; w_unstable = 1'b0;
    endtask

    task automatic send_cmd(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [31:0] erdata,
                            input logic [1:0] eresp);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 1);
        clear_obs();
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = strb;
        sb_q.push_back({rnw, erdata, eresp});
        if (eresp != 2'b00 && err_exp < 255) err_exp++;
        tick();
        cmd_valid = 1'b0;
        chk("cmd_taken", 32'(cmd_ready), 0);
    endtask

    task automatic wait_rsp(input int stall);
        int   n = 0;
        exp_t e;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("sb_depth", 32'(sb_q.size()), 1);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        chk("rsp_rnw", 32'(rsp_rnw), 32'(e.rnw));
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
        chk("err_count", 32'(err_count), 32'(err_exp));
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", 32'(rsp_valid), 1);
            chk("stall_rdata", rsp_rdata, e.rdata);
            chk("stall_resp", 32'(rsp_resp), 32'(e.resp));
            chk("stall_cmd_ready", 32'(cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_dropped", 32'(rsp_valid), 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_awvalid"}, 32'(m_axi_awvalid), 0);
        chk({tag, "_wvalid"}, 32'(m_axi_wvalid), 0);
        chk({tag, "_bready"}, 32'(m_axi_bready), 0);
        chk({tag, "_arvalid"}, 32'(m_axi_arvalid), 0);
        chk({tag, "_rready"}, 32'(m_axi_rready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_resp"}, 32'(rsp_resp), 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_err_count"}, 32'(err_count), 0);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_rnw   = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        chk_idle_outputs("reset");
        reset = 1'b0;
        tick();
        chk("post_reset_cmd_ready", 32'(cmd_ready), 1);

        // Zero-wait write with cycle-exact latency
        send_cmd(1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00);
        chk("c1_awvalid", 32'(m_axi_awvalid), 1);
        chk("c1_wvalid", 32'(m_axi_wvalid), 1);
        chk("c1_awaddr", m_axi_awaddr, 32'h0000_0008);
        chk("c1_wdata", m_axi_wdata, 32'hDEAD_BEEF);
        chk("c1_wstrb", 32'(m_axi_wstrb), 32'hF);
        tick();
        chk("c2_bready", 32'(m_axi_bready), 1);
        chk("c2_awvalid", 32'(m_axi_awvalid), 0);
        tick();
        chk("c3_rsp_valid", 32'(rsp_valid), 1);
        wait_rsp(0);
        chk("w1_b_hs", 32'(b_hs), 1);

        // Write with AW delayed three cycles
        aw_delay = 3;
        send_cmd(1'b0, 32'h0000_0100, 32'hCAFE_F00D, 4'h3, 32'h0, 2'b00);
        wait_rsp(0);
        chk("w2_aw_high", 32'(aw_high), 4);
        chk("w2_w_high", 32'(w_high), 1);
        chk("w2_aw_stable", 32'(aw_unstable), 0);
        chk("w2_aw_hs", 32'(aw_hs), 1);
        chk("w2_w_hs", 32'(w_hs), 1);
        chk("w2_b_hs", 32'(b_hs), 1);
        chk("w2_awaddr", cap_awaddr, 32'h0000_0100);
        chk("w2_wdata", cap_wdata, 32'hCAFE_F00D);
        chk("w2_wstrb", 32'(cap_wstrb), 32'h3);

        // Write with W delayed two cycles
        aw_delay = 0;
        w_delay  = 2;
        send_cmd(1'b0, 32'h0000_0104, 32'h0102_0304, 4'hC, 32'h0, 2'b00);
        wait_rsp(0);
        chk("w3_aw_high", 32'(aw_high), 1);
        chk("w3_w_high", 32'(w_high), 3);
        chk("w3_w_stable", 32'(w_unstable), 0);
        chk("w3_b_hs", 32'(b_hs), 1);
        w_delay = 0;

        // Read with R delayed two cycles
        r_delay    = 2;
        r_data_cfg = 32'h1234_5678;
        send_cmd(1'b1, 32'h0000_0004, 32'h0, 4'h0, 32'h1234_5678, 2'b00);
        wait_rsp(0);
        chk("r1_araddr", cap_araddr, 32'h0000_0004);
        chk("r1_ar_hs", 32'(ar_hs), 1);
        chk("r1_r_hs", 32'(r_hs), 1);
        r_delay = 0;

        // Stray B/R valids while idle must be ignored
        spur = 1'b1;
        repeat (3) tick();
        chk("spur_rsp_valid", 32'(rsp_valid), 0);
        chk("spur_err_count", 32'(err_count), 32'(err_exp));
        chk("spur_cmd_ready", 32'(cmd_ready), 1);
        spur = 1'b0;
        tick();

        // User holds off the completion for five cycles
        r_data_cfg = 32'hA5A5_5A5A;
        send_cmd(1'b1, 32'h0000_0020, 32'h0, 4'h0, 32'hA5A5_5A5A, 2'b00);
        wait_rsp(5);
        chk("stall_next_cmd_ready", 32'(cmd_ready), 1);

        // SLVERR read, then saturate the error counter
        r_resp_cfg = 2'b10;
        r_data_cfg = 32'h0000_0BAD;
        send_cmd(1'b1, 32'h0000_0040, 32'h0, 4'h0, 32'h0000_0BAD, 2'b10);
        wait_rsp(0);
        chk("err_one", 32'(err_count), 1);
        for (int i = 0; i < 256; i++) begin
            send_cmd(1'b1, 32'h0000_0040, 32'h0, 4'h0, 32'h0000_0BAD, 2'b10);
            wait_rsp(0);
        end
        chk("err_saturated", 32'(err_count), 32'hFF);
        r_resp_cfg = 2'b00;

        // Reset while waiting in WR_RESP
        b_delay = 10;
        send_cmd(1'b0, 32'h0000_0080, 32'h5555_AAAA, 4'hF, 32'h0, 2'b00);
        n = 0;
        while (!m_axi_bready && n < 20) begin
            tick();
            n++;
        end
        chk("mid_bready", 32'(m_axi_bready), 1);
        reset = 1'b1;
        tick();
        chk_idle_outputs("midreset");
        reset = 1'b0;
        sb_q.delete();
        err_exp = 0;
        b_delay = 0;
        tick();
        chk("midreset_cmd_ready", 32'(cmd_ready), 1);
        r_data_cfg = 32'h0BAD_CAFE;
        send_cmd(1'b1, 32'h0000_000C, 32'h0, 4'h0, 32'h0BAD_CAFE, 2'b00);
        wait_rsp(0);
        chk("post_reset_araddr", cap_araddr, 32'h0000_000C);

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule
